// File: rtl/time_set_controller.sv
// time_set_controller
//   Mode/adjust sequencer for the alarm clock digit chains. It debounces the five push-buttons
//   and runs the mode FSM. It gates the clock chain's count enable and issues one-cycle up/down
//   adjust pulses to the clock and alarm hour/minute counters. It also drives the alarm ringing
//   and display-blink flags. All outputs are registered.
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   btn_c/l/r/u/d            raw button levels (already synchronised)
//   alarm_en, alarm_match    alarm armed; clock time equals alarm time (level)
//   run_en                   count enable for the clock chain, high only in RUN
//   clk_/alm_ hr_/min_ up/dn one-cycle adjust pulses
//   mode                     0 RUN, 1 ADJ_CLK_HR, 2 ADJ_CLK_MIN, 3 ADJ_ALM_HR, 4 ADJ_ALM_MIN
//   blink                    blank phase of the field being adjusted
//   ringing                  alarm sounding
module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BLINK_CYCLES    = 8,
  parameter int unsigned RING_CYCLES     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_c,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       alarm_en,
  input  logic       alarm_match,
  output logic       run_en,
  output logic       clk_hr_up,
  output logic       clk_hr_dn,
  output logic       clk_min_up,
  output logic       clk_min_dn,
  output logic       alm_hr_up,
  output logic       alm_hr_dn,
  output logic       alm_min_up,
  output logic       alm_min_dn,
  output logic [2:0] mode,
  output logic       blink,
  output logic       ringing
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BlW = $clog2(BLINK_CYCLES + 1);
  localparam int unsigned RgW = $clog2(RING_CYCLES + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BlW-1:0] BlLast = BlW'(BLINK_CYCLES - 1);
  localparam logic [RgW-1:0] RgLast = RgW'(RING_CYCLES - 1);

  localparam int unsigned BtnC = 0;
  localparam int unsigned BtnL = 1;
  localparam int unsigned BtnR = 2;
  localparam int unsigned BtnU = 3;
  localparam int unsigned BtnD = 4;

  typedef enum logic [2:0] {
    StRun    = 3'd0,
    StClkHr  = 3'd1,
    StClkMin = 3'd2,
    StAlmHr  = 3'd3,
    StAlmMin = 3'd4
  } state_e;

  // ---------------------------------------------------------------- debounce
  logic [4:0]          raw;
  logic [4:0][DbW-1:0] db_cnt_q, db_cnt_d;
  logic [4:0]          acc_q, acc_d;
  logic [4:0]          press_q, press_d;

  assign raw = {btn_d, btn_u, btn_r, btn_l, btn_c};

  always_comb begin
    db_cnt_d = '0;
    acc_d    = acc_q;
    for (int i = 0; i < 5; i++) begin
      if (raw[i] != acc_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          acc_d[i] = raw[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
    // Registered press pulse: acted on by the FSM one edge after acceptance.
    press_d = acc_d & ~acc_q;
  end

  // ---------------------------------------------------------------- mode FSM
  state_e         state_q, state_d;
  logic [7:0]     pulse_q, pulse_d;
  logic           run_en_q, run_en_d;
  logic [BlW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_q, blink_d;
  logic [RgW-1:0] ring_cnt_q, ring_cnt_d;
  logic           ringing_q, ringing_d;
  logic           match_q;
  logic           consumed;
  logic           field_reset;
  logic [1:0]     field_idx;

  always_comb begin
    state_d     = state_q;
    pulse_d     = '0;
    field_reset = 1'b0;
    field_idx   = 2'd0;
    // A press while ringing only silences the alarm.
    consumed    = ringing_q & (|press_q);

    unique case (state_q)
      StClkMin: field_idx = 2'd1;
      StAlmHr:  field_idx = 2'd2;
      StAlmMin: field_idx = 2'd3;
      default:  field_idx = 2'd0;
    endcase

    if (!consumed) begin
      if (press_q[BtnC]) begin
        state_d     = (state_q == StRun) ? StClkHr : StRun;
        field_reset = 1'b1;
      end else if (state_q != StRun) begin
        if (press_q[BtnR]) begin
          field_reset = 1'b1;
          case (state_q)
            StClkHr:  state_d = StClkMin;
            StClkMin: state_d = StAlmHr;
            StAlmHr:  state_d = StAlmMin;
            default:  state_d = StClkHr;
          endcase
        end else if (press_q[BtnL]) begin
          field_reset = 1'b1;
          case (state_q)
            StClkHr:  state_d = StAlmMin;
            StClkMin: state_d = StClkHr;
            StAlmHr:  state_d = StClkMin;
            default:  state_d = StAlmHr;
          endcase
        end else if (press_q[BtnU]) begin
          pulse_d[{field_idx, 1'b0}] = 1'b1;
        end else if (press_q[BtnD]) begin
          pulse_d[{field_idx, 1'b1}] = 1'b1;
        end
      end
    end

    run_en_d = (state_d == StRun);

    blink_cnt_d = blink_cnt_q + BlW'(1);
    blink_d     = blink_q;
    if (state_d == StRun || field_reset) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BlLast) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end

    ringing_d  = ringing_q;
    ring_cnt_d = ring_cnt_q;
    if (ringing_q) begin
      if (!alarm_en || consumed || ring_cnt_q == RgLast) begin
        ringing_d  = 1'b0;
        ring_cnt_d = '0;
      end else begin
        ring_cnt_d = ring_cnt_q + RgW'(1);
      end
    end else if (alarm_match && !match_q && alarm_en && state_q == StRun) begin
      ringing_d  = 1'b1;
      ring_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q    <= '0;
      acc_q       <= '0;
      press_q     <= '0;
      state_q     <= StRun;
      pulse_q     <= '0;
      run_en_q    <= 1'b1;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      ring_cnt_q  <= '0;
      ringing_q   <= 1'b0;
      match_q     <= 1'b0;
    end else begin
      db_cnt_q    <= db_cnt_d;
      acc_q       <= acc_d;
      press_q     <= press_d;
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      run_en_q    <= run_en_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      ring_cnt_q  <= ring_cnt_d;
      ringing_q   <= ringing_d;
      match_q     <= alarm_match;
    end
  end

  assign mode       = state_q;
  assign run_en     = run_en_q;
  assign clk_hr_up  = pulse_q[0];
  assign clk_hr_dn  = pulse_q[1];
  assign clk_min_up = pulse_q[2];
  assign clk_min_dn = pulse_q[3];
  assign alm_hr_up  = pulse_q[4];
  assign alm_hr_dn  = pulse_q[5];
  assign alm_min_up = pulse_q[6];
  assign alm_min_dn = pulse_q[7];
  assign blink      = blink_q;
  assign ringing    = ringing_q;

endmodule

// File: tb/tb_time_set_controller.sv
module tb_time_set_controller;
  localparam int N  = 4;
  localparam int BC = 8;
  localparam int RC = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;  // bit0 c, 1 l, 2 r, 3 u, 4 d
  logic       alarm_en, alarm_match;
  logic       run_en, blink, ringing;
  logic [2:0] mode;
  logic [7:0] pulses;

  int compared   = 0;
  int mismatched = 0;

  time_set_controller #(
    .DEBOUNCE_CYCLES(N),
    .BLINK_CYCLES   (BC),
    .RING_CYCLES    (RC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_c      (btn[0]),
    .btn_l      (btn[1]),
    .btn_r      (btn[2]),
    .btn_u      (btn[3]),
    .btn_d      (btn[4]),
    .alarm_en   (alarm_en),
    .alarm_match(alarm_match),
    .run_en     (run_en),
    .clk_hr_up  (pulses[0]),
    .clk_hr_dn  (pulses[1]),
    .clk_min_up (pulses[2]),
    .clk_min_dn (pulses[3]),
    .alm_hr_up  (pulses[4]),
    .alm_hr_dn  (pulses[5]),
    .alm_min_up (pulses[6]),
    .alm_min_dn (pulses[7]),
    .mode       (mode),
    .blink      (blink),
    .ringing    (ringing)
  );

  always #5 clk = ~clk;

  // Reference model: mode as an integer, blink from cycles spent in the current field,
  // ringing from cycles elapsed since the alarm started.
  logic [4:0] m_acc;
  int         m_run[5];
  logic [4:0] m_pend;
  int         m_mode;
  bit         m_run_en;
  logic [7:0] m_pulses;
  int         m_age;
  bit         m_blink;
  bit         m_ring;
  int         m_ring_age;
  bit         m_prev;

  task automatic model_reset();
    m_acc = '0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    m_pend = '0; m_mode = 0; m_run_en = 1'b1; m_pulses = '0;
    m_age = 0; m_blink = 1'b0; m_ring = 1'b0; m_ring_age = 0; m_prev = 1'b0;
  endtask

  task automatic model_edge();
    logic [4:0] new_press;
    bit consumed;
    bit field_evt;
    int old_mode;
    if (rst) begin
      model_reset();
      return;
    end
    new_press = '0;
    for (int i = 0; i < 5; i++) begin
      if (btn[i] != m_acc[i]) begin
        m_run[i]++;
        if (m_run[i] == N) begin
          m_acc[i] = btn[i];
          m_run[i] = 0;
          new_press[i] = btn[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_pulses  = '0;
    field_evt = 1'b0;
    old_mode  = m_mode;
    consumed  = m_ring && (m_pend != 0);
    if (!consumed && m_pend != 0) begin
      if (m_pend[0]) begin
        m_mode = (m_mode == 0) ? 1 : 0;
        field_evt = 1'b1;
      end else if (m_mode != 0) begin
        if (m_pend[2]) begin
          m_mode = (m_mode % 4) + 1;
          field_evt = 1'b1;
        end else if (m_pend[1]) begin
          m_mode = (m_mode == 1) ? 4 : m_mode - 1;
          field_evt = 1'b1;
        end else if (m_pend[3]) begin
          m_pulses[(m_mode - 1) * 2] = 1'b1;
        end else if (m_pend[4]) begin
          m_pulses[(m_mode - 1) * 2 + 1] = 1'b1;
        end
      end
    end
    if (field_evt) m_age = 0;
    else if (m_mode != 0) m_age++;
    m_blink  = (m_mode != 0) && (((m_age / BC) % 2) == 1);
    m_run_en = (m_mode == 0);
    if (m_ring) begin
      m_ring_age++;
      if (!alarm_en || consumed || m_ring_age >= RC) m_ring = 1'b0;
    end else if (alarm_match && !m_prev && alarm_en && old_mode == 0) begin
      m_ring = 1'b1;
      m_ring_age = 0;
    end
    m_prev = alarm_match;
    m_pend = new_press;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ":mode"}, {5'b0, mode}, 8'(m_mode));
    chk({tag, ":run_en"}, {7'b0, run_en}, {7'b0, m_run_en});
    chk({tag, ":pulses"}, pulses, m_pulses);
    chk({tag, ":blink"}, {7'b0, blink}, {7'b0, m_blink});
    chk({tag, ":ringing"}, {7'b0, ringing}, {7'b0, m_ring});
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  // Hold a button long enough for one accepted press, then release and let it settle.
  task automatic press(input int b, input string tag);
    btn[b] = 1'b1;
    repeat (N + 1) step(tag);
    btn[b] = 1'b0;
    repeat (N + 2) step(tag);
  endtask

  initial begin
    rst = 1'b1; btn = '0; alarm_en = 1'b0; alarm_match = 1'b0;
    model_reset();
    step("reset");
    step("reset");
    chk("reset_mode", {5'b0, mode}, 8'd0);
    chk("reset_run_en", {7'b0, run_en}, 8'd1);
    chk("reset_pulses", pulses, 8'd0);
    chk("reset_blink_ring", {6'b0, blink, ringing}, 8'd0);
    rst = 1'b0;

    // 1: long centre hold gives exactly one transition at edge N+1
    btn[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step("t1");
      if (i == N) chk("t1_mode_before", {5'b0, mode}, 8'd0);
      if (i == N + 1) begin
        chk("t1_mode_edge5", {5'b0, mode}, 8'd1);
        chk("t1_run_en_edge5", {7'b0, run_en}, 8'd0);
      end
    end
    btn[0] = 1'b0;
    repeat (N + 2) step("t1_rel");
    chk("t1_single", {5'b0, mode}, 8'd1);

    // 2: short glitch is rejected
    btn[0] = 1'b1;
    repeat (N - 1) step("t2");
    btn[0] = 1'b0;
    repeat (N + 2) step("t2");
    chk("t2_glitch", {5'b0, mode}, 8'd1);

    // 3: right walks the ring forward, left steps back, up pulses the current field
    press(2, "t3r"); chk("t3_r1", {5'b0, mode}, 8'd2);
    press(2, "t3r"); chk("t3_r2", {5'b0, mode}, 8'd3);
    press(2, "t3r"); chk("t3_r3", {5'b0, mode}, 8'd4);
    press(2, "t3r"); chk("t3_r4", {5'b0, mode}, 8'd1);
    press(1, "t3l"); chk("t3_l", {5'b0, mode}, 8'd4);
    btn[3] = 1'b1;
    repeat (N) step("t3u");
    chk("t3_u_before", pulses, 8'h00);
    step("t3u");
    chk("t3_u_pulse", pulses, 8'h40);
    step("t3u");
    chk("t3_u_after", pulses, 8'h00);
    btn[3] = 1'b0;
    repeat (N + 2) step("t3u");

    // 4: centre beats up in the same cycle
    press(2, "t4"); press(2, "t4");
    chk("t4_start", {5'b0, mode}, 8'd2);
    btn[0] = 1'b1; btn[3] = 1'b1;
    repeat (N + 1) step("t4");
    chk("t4_mode", {5'b0, mode}, 8'd0);
    chk("t4_pulses", pulses, 8'h00);
    btn[0] = 1'b0; btn[3] = 1'b0;
    repeat (N + 2) step("t4");

    // 5: alarm ring, press silences, auto-timeout, disable, edge in ADJ ignored
    alarm_en = 1'b1; alarm_match = 1'b1;
    step("t5");
    chk("t5_ring_on", {7'b0, ringing}, 8'd1);
    btn[4] = 1'b1;
    repeat (N + 1) step("t5d");
    chk("t5_silenced", {7'b0, ringing}, 8'd0);
    chk("t5_mode", {5'b0, mode}, 8'd0);
    chk("t5_no_pulse", pulses, 8'h00);
    btn[4] = 1'b0;
    repeat (N + 2) step("t5d");
    alarm_match = 1'b0; step("t5");
    alarm_match = 1'b1; step("t5");
    chk("t5_ring2", {7'b0, ringing}, 8'd1);
    repeat (RC - 1) step("t5hold");
    chk("t5_ring_last", {7'b0, ringing}, 8'd1);
    step("t5hold");
    chk("t5_timeout", {7'b0, ringing}, 8'd0);
    alarm_match = 1'b0; step("t5");
    alarm_match = 1'b1; step("t5");
    alarm_en = 1'b0; step("t5");
    chk("t5_disable", {7'b0, ringing}, 8'd0);
    alarm_en = 1'b1; alarm_match = 1'b0;
    press(0, "t5adj");
    alarm_match = 1'b1; step("t5adj");
    press(0, "t5adj");
    chk("t5_adj_edge", {7'b0, ringing}, 8'd0);

    // 6: blink in ADJ_ALM_HR, then reset mid-operation
    alarm_en = 1'b0;
    press(0, "t6"); press(2, "t6");
    btn[2] = 1'b1;
    repeat (N + 1) step("t6");
    chk("t6_mode", {5'b0, mode}, 8'd3);
    btn[2] = 1'b0;
    repeat (BC - 1) step("t6");
    chk("t6_blink_lo", {7'b0, blink}, 8'd0);
    step("t6");
    chk("t6_blink_hi", {7'b0, blink}, 8'd1);
    repeat (BC) step("t6");
    chk("t6_blink_lo2", {7'b0, blink}, 8'd0);
    rst = 1'b1;
    step("t6rst");
    chk("t6_rst_mode", {5'b0, mode}, 8'd0);
    chk("t6_rst_run_en", {7'b0, run_en}, 8'd1);
    chk("t6_rst_blink_ring", {6'b0, blink, ringing}, 8'd0);
    rst = 1'b0;

    // Randomised traffic against the model
    alarm_en = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
      if ($urandom_range(0, 24) == 0) alarm_match = ~alarm_match;
      if (alarm_en ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 9) == 0))
        alarm_en = ~alarm_en;
      rst = ($urandom_range(0, 399) == 0);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
